bin2bcd: RTL and testbench

BIN2BCD -- requirements
Module: bin2bcd

---
 rtl/bin2bcd_pkg.sv | 22 ++
 rtl/bin2bcd_if.sv | 36 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd.sv | 116 +++++++++++
 tb/tb_bin2bcd.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared widths and FSM state type for the bin2bcd block
//
// Purpose : constants and the two-state FSM encoding used by bin2bcd,
//           its bus interface and its testbench.
// Contents: BIN_W  - binary operand width
//           BCD_W  - packed BCD result width (2-bit hundreds, 4-bit tens, 4-bit ones)
//           ITER   - shift iterations per conversion (one per operand bit)
//           CNT_W  - iteration counter width
//           state_t - {IDLE, SHIFT}
package bin2bcd_pkg;

  localparam int BIN_W = 8;
  localparam int BCD_W = 10;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_if.sv
// rtl/bin2bcd_if.sv - request/result bundle between a requester and bin2bcd
//
// Purpose : groups the conversion request and result signals.
// Signals : start   - conversion request, sampled on rising clk
//           bin_in  - unsigned operand, sampled together with start
//           busy    - conversion in progress
//           done    - one-cycle pulse, new result on bcd_out
//           bcd_out - packed BCD result {hundreds[1:0], tens[3:0], ones[3:0]}
// Modports: master - requester side (drives start/bin_in)
//           slave  - converter side (drives busy/done/bcd_out)
interface bin2bcd_if;
  import bin2bcd_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction (add 3 when digit >= 5)
//
// Purpose : combinational pre-shift correction for one 4-bit BCD digit, so
//           that the following left shift carries correctly into the next digit.
// Ports   : digit_in  - current BCD digit (0..9)
//           digit_out - digit_in + 3 when digit_in >= 5, else digit_in
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - iterative 8-bit binary to 3-digit BCD converter
//
// Purpose : converts an 8-bit unsigned operand to packed BCD with the
//           shift-add-3 algorithm, one operand bit per clock. Fixed latency:
//           done pulses in the cycle after the 8th shift edge.
// Ports   : clk   - single clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - bin2bcd_if.slave (start, bin_in in; busy, done, bcd_out out)
module bin2bcd
  import bin2bcd_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  bin2bcd_if.slave bus
);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [1:0]         hund_q, hund_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [3:0]         tens_adj;
  logic [3:0]         ones_adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  // Hundreds is never >= 5 before the final shift (max pre-shift value is 1),
  // so only tens and ones get corrected.
  bcd_digit_adj u_adj_tens (
    .digit_in  (tens_q),
    .digit_out (tens_adj)
  );

  bcd_digit_adj u_adj_ones (
    .digit_in  (ones_q),
    .digit_out (ones_adj)
  );

  // Corrected digits and operand shifted left as one vector; the bit shifted
  // out of the 2-bit hundreds digit falls off the top (it is always 0).
  assign shifted = {hund_q, tens_adj, ones_adj, sh_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin_in;
          hund_d  = '0;
          tens_d  = '0;
          ones_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        hund_d = shifted[BCD_W+BIN_W-1 -: 2];
        tens_d = shifted[BIN_W+7 -: 4];
        ones_d = shifted[BIN_W+3 -: 4];
        sh_d   = shifted[BIN_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          // Only the completed digits ever reach bcd_out.
          bcd_d   = shifted[BCD_W+BIN_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered busy mirrors the state being entered.
    busy_d = (state_d == SHIFT);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd.sv
// tb/tb_bin2bcd.sv - self-checking testbench for bin2bcd
module tb_bin2bcd;
  import bin2bcd_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bin2bcd_if bus ();

  bin2bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [31:0] ref_bcd(input int n);
    logic [31:0] r;
    r = ((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done, sampling on the falling edge. lat counts
  // falling edges since the accepting edge; busy_cnt counts busy samples
  // seen before done. lat = -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic launch(input int n);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = n[7:0];
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic convert(input int n, input bit full);
    int lat, bc;
    launch(n);
    wait_done(lat, bc);
    check($sformatf("result_%0d", n), {22'd0, bus.bcd_out}, ref_bcd(n));
    if (full) begin
      check($sformatf("latency_%0d", n), lat, 9);
      check($sformatf("busy_cycles_%0d", n), bc, 8);
      check($sformatf("busy_in_done_%0d", n), bus.busy, 0);
      @(negedge clk);
      check($sformatf("done_one_cycle_%0d", n), bus.done, 0);
      check($sformatf("hold_%0d", n), {22'd0, bus.bcd_out}, ref_bcd(n));
    end
  endtask

  initial begin
    int lat, bc, lat2, dones, n;
    vectors     = 0;
    miscompares = 0;
    bus.start   = 1'b0;
    bus.bin_in  = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_bcd", {22'd0, bus.bcd_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operands
    convert(0, 1'b1);
    convert(255, 1'b1);
    convert(99, 1'b1);
    convert(100, 1'b1);
    convert(9, 1'b1);

    // start while busy is ignored
    launch(200);
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 8'd17;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 8'd77;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_result", {22'd0, bus.bcd_out}, ref_bcd(200));

    // Back-to-back: request held in the done cycle
    launch(123);
    wait_done(lat, bc);
    check("b2b_first", {22'd0, bus.bcd_out}, ref_bcd(123));
    bus.start  = 1'b1;
    bus.bin_in = 8'd45;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat2, bc);
    check("b2b_spacing", lat2, 9);
    check("b2b_second", {22'd0, bus.bcd_out}, ref_bcd(45));

    // Reset mid-conversion
    launch(88);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_bcd", {22'd0, bus.bcd_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_bcd_after", {22'd0, bus.bcd_out}, 0);

    // Exhaustive sweep
    for (int k = 0; k < 256; k++) convert(k, 1'b0);

    // Random operands with full timing checks
    for (int k = 0; k < 40; k++) begin
      n = int'($urandom_range(255, 0));
      convert(n, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
